// File: rtl/multi_issue_inst_buffer.sv
// Parametrised N-in/M-out circular instruction buffer between fetch and decode.
// Optional stall/starvation counters are enabled by defining INST_BUF_PERF_CNT_EN.
module multi_issue_inst_buffer #(
  parameter int DATA_WIDTH   = 32,
  parameter int BUFFER_DEPTH = 16,
  parameter int FETCH_WIDTH  = 3,
  parameter int DECODE_WIDTH = 3
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 flush_i,
  input  logic [FETCH_WIDTH-1:0]               fetch_valid_i,
  input  logic [FETCH_WIDTH*DATA_WIDTH-1:0]    instruction_i,
  input  logic [FETCH_WIDTH*DATA_WIDTH-1:0]    pc_i,
  input  logic [FETCH_WIDTH*DATA_WIDTH-1:0]    imm_i,
  input  logic [FETCH_WIDTH-1:0]               branch_prediction_i,
  output logic                                 fetch_ready_o,
  output logic [DECODE_WIDTH-1:0]              decode_valid_o,
  output logic [DECODE_WIDTH*DATA_WIDTH-1:0]   instruction_o,
  output logic [DECODE_WIDTH*DATA_WIDTH-1:0]   pc_o,
  output logic [DECODE_WIDTH*DATA_WIDTH-1:0]   imm_o,
  output logic [DECODE_WIDTH-1:0]              branch_prediction_o,
  input  logic [DECODE_WIDTH-1:0]              decode_ready_i,
  output logic                                 buffer_empty_o,
  output logic                                 buffer_full_o,
  output logic [$clog2(BUFFER_DEPTH):0]        occupancy_o,
  output logic [31:0]                          stall_cycles_o,
  output logic [31:0]                          starve_cycles_o
);

  localparam int PTR_W = $clog2(BUFFER_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(BUFFER_DEPTH);
  localparam logic [OCC_W-1:0] FETCH_C = OCC_W'(FETCH_WIDTH);

  logic [DATA_WIDTH-1:0]   inst_mem_q [BUFFER_DEPTH];
  logic [DATA_WIDTH-1:0]   pc_mem_q   [BUFFER_DEPTH];
  logic [DATA_WIDTH-1:0]   imm_mem_q  [BUFFER_DEPTH];
  logic [BUFFER_DEPTH-1:0] bp_mem_q;

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  logic             enq_fire_s;
  logic [OCC_W-1:0] enq_cnt_s;
  logic [OCC_W-1:0] deq_cnt_s;
  logic             deq_run_s;
  logic [FETCH_WIDTH-1:0] wr_en_s;
  logic [PTR_W-1:0] wr_idx_s [FETCH_WIDTH];

  assign buffer_empty_o = (occ_q == {OCC_W{1'b0}});
  assign buffer_full_o  = (occ_q == DEPTH_C);
  assign occupancy_o    = occ_q;

  // Free-space check and compaction of sparse fetch lanes onto consecutive slots.
  always_comb begin
    fetch_ready_o = ((DEPTH_C - occ_q) >= FETCH_C);
    enq_fire_s    = fetch_ready_o && (|fetch_valid_i) && !flush_i;
    enq_cnt_s     = {OCC_W{1'b0}};
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      wr_idx_s[k] = tail_q + enq_cnt_s[PTR_W-1:0];
      wr_en_s[k]  = enq_fire_s && fetch_valid_i[k];
      if (fetch_valid_i[k]) begin
        enq_cnt_s = enq_cnt_s + OCC_W'(1);
      end else begin
        enq_cnt_s = enq_cnt_s;
      end
    end
  end

  // Head-window read and in-order dequeue count (stops at the first gap).
  always_comb begin
    decode_valid_o      = {DECODE_WIDTH{1'b0}};
    instruction_o       = {(DECODE_WIDTH*DATA_WIDTH){1'b0}};
    pc_o                = {(DECODE_WIDTH*DATA_WIDTH){1'b0}};
    imm_o               = {(DECODE_WIDTH*DATA_WIDTH){1'b0}};
    branch_prediction_o = {DECODE_WIDTH{1'b0}};
    deq_cnt_s           = {OCC_W{1'b0}};
    deq_run_s           = 1'b1;
    for (int j = 0; j < DECODE_WIDTH; j++) begin
      decode_valid_o[j] = (OCC_W'(j) < occ_q);
      instruction_o[j*DATA_WIDTH +: DATA_WIDTH] = inst_mem_q[head_q + PTR_W'(j)];
      pc_o[j*DATA_WIDTH +: DATA_WIDTH]          = pc_mem_q[head_q + PTR_W'(j)];
      imm_o[j*DATA_WIDTH +: DATA_WIDTH]         = imm_mem_q[head_q + PTR_W'(j)];
      branch_prediction_o[j]                    = bp_mem_q[head_q + PTR_W'(j)];
      if (deq_run_s && decode_valid_o[j] && decode_ready_i[j]) begin
        deq_cnt_s = deq_cnt_s + OCC_W'(1);
      end else begin
        deq_run_s = 1'b0;
      end
    end
  end

  // Pointer/occupancy update; flush drops both same-cycle enqueue and dequeue.
  always_comb begin
    if (flush_i) begin
      head_d = {PTR_W{1'b0}};
      tail_d = {PTR_W{1'b0}};
      occ_d  = {OCC_W{1'b0}};
    end else if (enq_fire_s) begin
      head_d = head_q + deq_cnt_s[PTR_W-1:0];
      tail_d = tail_q + enq_cnt_s[PTR_W-1:0];
      occ_d  = occ_q + enq_cnt_s - deq_cnt_s;
    end else begin
      head_d = head_q + deq_cnt_s[PTR_W-1:0];
      tail_d = tail_q;
      occ_d  = occ_q - deq_cnt_s;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q <= {PTR_W{1'b0}};
      tail_q <= {PTR_W{1'b0}};
      occ_q  <= {OCC_W{1'b0}};
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  // Entry storage carries no reset; validity comes from occupancy alone.
  always_ff @(posedge clk) begin
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      if (wr_en_s[k]) begin
        inst_mem_q[wr_idx_s[k]] <= instruction_i[k*DATA_WIDTH +: DATA_WIDTH];
        pc_mem_q[wr_idx_s[k]]   <= pc_i[k*DATA_WIDTH +: DATA_WIDTH];
        imm_mem_q[wr_idx_s[k]]  <= imm_i[k*DATA_WIDTH +: DATA_WIDTH];
        bp_mem_q[wr_idx_s[k]]   <= branch_prediction_i[k];
      end
    end
  end

`ifdef INST_BUF_PERF_CNT_EN
  logic [31:0] stall_q, stall_d, starve_q, starve_d;

  // Saturating counters; flush does not clear them.
  always_comb begin
    if ((|fetch_valid_i) && !fetch_ready_o && !flush_i && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end else begin
      stall_d = stall_q;
    end
    if (buffer_empty_o && decode_ready_i[0] && (starve_q != 32'hFFFF_FFFF)) begin
      starve_d = starve_q + 32'd1;
    end else begin
      starve_d = starve_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q  <= 32'd0;
      starve_q <= 32'd0;
    end else begin
      stall_q  <= stall_d;
      starve_q <= starve_d;
    end
  end

  assign stall_cycles_o  = stall_q;
  assign starve_cycles_o = starve_q;
`else
  assign stall_cycles_o  = 32'd0;
  assign starve_cycles_o = 32'd0;
`endif

endmodule
